// File: rtl/puf_query_master.sv
// Batch query master for a PUF mapping responder: issues a run of challenges and
// collects one response per challenge. Define PUF_QUERY_LFSR_EN for LFSR challenge stepping.
module puf_query_master #(
  parameter int unsigned IN_WIDTH  = 128,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned TIMEOUT   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [IN_WIDTH-1:0]  seed,
  input  logic [7:0]           count,
  output logic                 map_trigger,
  output logic [IN_WIDTH-1:0]  map_challenge,
  input  logic                 map_done,
  input  logic [OUT_WIDTH-1:0] map_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [OUT_WIDTH-1:0] resp_data,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  localparam int unsigned CNT_W = 8;
  // wait_cnt lags cycles-since-trigger by one, so the last WAIT cycle sees TIMEOUT-2
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    DELIVER = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [7:0]       remaining;

  function automatic logic [IN_WIDTH-1:0] first_chal(input logic [IN_WIDTH-1:0] s);
`ifdef PUF_QUERY_LFSR_EN
    // an all-zero state would lock the LFSR
    return (s == '0) ? IN_WIDTH'(1) : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [IN_WIDTH-1:0] next_chal(input logic [IN_WIDTH-1:0] c);
`ifdef PUF_QUERY_LFSR_EN
    return {c[IN_WIDTH-2:0], c[127] ^ c[125] ^ c[100] ^ c[98]};
`else
    return c + IN_WIDTH'(1);
`endif
  endfunction

  // Trigger and done are raised on entry to ISSUE/FINISH so they cover exactly that cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      remaining     <= '0;
      map_trigger   <= 1'b0;
      map_challenge <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      map_trigger <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            map_challenge <= first_chal(seed);
            remaining     <= count;
            timeout_err   <= 1'b0;
            busy          <= 1'b1;
            if (count == 8'd0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state       <= ISSUE;
              map_trigger <= 1'b1;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (map_done) begin
            resp_data  <= map_data;
            resp_valid <= 1'b1;
            state      <= DELIVER;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            state       <= FINISH;
            done        <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        DELIVER: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            remaining  <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              map_challenge <= next_chal(map_challenge);
              state         <= ISSUE;
              map_trigger   <= 1'b1;
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_query_master.sv
// Directed bench for puf_query_master (default increment build, TIMEOUT=32).
module tb_puf_query_master;

  localparam int unsigned IN_W  = 128;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned TO    = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [IN_W-1:0]  seed;
  logic [7:0]       count;
  logic             map_trigger;
  logic [IN_W-1:0]  map_challenge;
  logic             map_done;
  logic [OUT_W-1:0] map_data;
  logic             resp_valid;
  logic             resp_ready;
  logic [OUT_W-1:0] resp_data;
  logic             busy;
  logic             done;
  logic             timeout_err;

  int ncmp = 0;
  int nfail = 0;
  int trig_cnt = 0;
  int done_cnt = 0;
  int snap;

  puf_query_master #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .count(count),
    .map_trigger(map_trigger), .map_challenge(map_challenge),
    .map_done(map_done), .map_data(map_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (map_trigger) trig_cnt <= trig_cnt + 1;
    if (done)        done_cnt <= done_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [IN_W-1:0] s, input logic [7:0] n);
    seed  = s;
    count = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Responder: map_done exactly lat cycles after the trigger cycle
  task automatic run_query(input logic [IN_W-1:0] exp_chal, input int lat,
                           input logic [OUT_W-1:0] data);
    for (int i = 0; i < 6 && !map_trigger; i++) step();
    chk("trigger_seen", map_trigger, 1);
    chk("challenge", map_challenge, exp_chal);
    step();
    chk("trigger_one_cycle", map_trigger, 0);
    repeat (lat - 1) step();
    chk("challenge_stable", map_challenge, exp_chal);
    chk("resp_not_early", resp_valid, 0);
    map_done = 1'b1;
    map_data = data;
    step();
    map_done = 1'b0;
    map_data = '0;
    chk("resp_valid", resp_valid, 1);
    chk("resp_data", resp_data, data);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; seed = '0; count = '0;
    map_done = 1'b0; map_data = '0; resp_ready = 1'b1;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_trigger", map_trigger, 0);
    chk("rst_challenge", map_challenge, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout_err, 0);
    reset = 1'b0;
    step();

    // Three-challenge batch, latency 16, ready tied high
    snap = trig_cnt;
    kick(128'd5, 8'd3);
    chk("busy_after_start", busy, 1);
    run_query(128'd5, 16, 16'hA001);
    run_query(128'd6, 16, 16'hA002);
    run_query(128'd7, 16, 16'hA003);
    step();
    chk("batch_done", done, 1);
    chk("batch_resp_cleared", resp_valid, 0);
    step();
    chk("batch_done_one_cycle", done, 0);
    chk("batch_idle_busy", busy, 0);
    chk("batch_no_timeout", timeout_err, 0);
    chk("batch_triggers", 128'(trig_cnt - snap), 3);

    // Empty batch
    snap = trig_cnt;
    kick(128'd77, 8'd0);
    chk("empty_done", done, 1);
    chk("empty_no_trigger", map_trigger, 0);
    step();
    chk("empty_done_one_cycle", done, 0);
    chk("empty_trig_count", 128'(trig_cnt - snap), 0);

    // Silent responder: timeout 32 cycles after the trigger
    snap = trig_cnt;
    kick(128'h40, 8'd3);
    chk("to_trigger", map_trigger, 1);
    repeat (TO - 1) step();
    chk("to_not_yet", timeout_err, 0);
    chk("to_busy_waiting", busy, 1);
    step();
    chk("to_flag", timeout_err, 1);
    chk("to_done", done, 1);
    repeat (10) step();
    chk("to_sticky", timeout_err, 1);
    chk("to_idle", busy, 0);
    chk("to_single_trigger", 128'(trig_cnt - snap), 1);

    // Backpressure: ready low 10 cycles, stray map_done in DELIVER ignored
    resp_ready = 1'b0;
    snap = trig_cnt;
    kick(128'h100, 8'd2);
    chk("bp_timeout_cleared", timeout_err, 0);
    run_query(128'h100, 4, 16'hBEEF);
    map_done = 1'b1;
    map_data = 16'h1234;
    step();
    map_done = 1'b0;
    map_data = '0;
    repeat (9) begin
      chk("bp_valid_hold", resp_valid, 1);
      chk("bp_data_hold", resp_data, 16'hBEEF);
      step();
    end
    chk("bp_no_new_trigger", 128'(trig_cnt - snap), 1);
    resp_ready = 1'b1;
    step();
    chk("bp_accept_clears", resp_valid, 0);
    chk("bp_next_trigger", map_trigger, 1);
    run_query(128'h101, 3, 16'h0C0D);
    step();
    chk("bp_done", done, 1);
    step();

    // All-ones seed wraps to zero
    kick({IN_W{1'b1}}, 8'd2);
    run_query({IN_W{1'b1}}, 2, 16'h1111);
    run_query(128'd0, 2, 16'h2222);
    step();
    chk("wrap_done", done, 1);
    step();

    // Reset during WAIT
    kick(128'd9, 8'd2);
    step(); step();
    snap = done_cnt;
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_challenge", map_challenge, 0);
    chk("arst_resp_data", resp_data, 0);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_trigger", map_trigger, 0);
    chk("arst_timeout", timeout_err, 0);
    step(); step();
    reset = 1'b0;
    repeat (3) step();
    chk("arst_no_done", 128'(done_cnt - snap), 0);
    kick(128'h20, 8'd1);
    run_query(128'h20, 5, 16'h5A5A);
    step();
    chk("post_rst_done", done, 1);
    chk("post_rst_no_timeout", timeout_err, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/puf_query_master.md
PUF_QUERY_MASTER -- requirements
Module: puf_query_master

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 128, meaning challenge width.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, meaning response width.
REQ-003 SHALL have parameter TIMEOUT, default 32, meaning the maximum number of cycles to wait for map_done per challenge (range 2..255).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a batch.
REQ-007 SHALL have port seed  input  IN_WIDTH  first challenge, sampled when start is accepted.
REQ-008 SHALL have port count  input  8  number of challenges in the batch, sampled when start is accepted.
REQ-009 SHALL have port map_trigger  output  1  one-cycle pulse to the mapping responder.
REQ-010 SHALL have port map_challenge  output  IN_WIDTH  challenge presented to the responder.
REQ-011 SHALL have port map_done  input  1  responder completion pulse.
REQ-012 SHALL have port map_data  input  OUT_WIDTH  responder result, valid while map_done is high.
REQ-013 SHALL have port resp_valid  output  1  captured response available.
REQ-014 SHALL have port resp_ready  input  1  downstream accepts the response.
REQ-015 SHALL have port resp_data  output  OUT_WIDTH  captured response.
REQ-016 SHALL have port busy  output  1  batch in progress.
REQ-017 SHALL have port done  output  1  one-cycle batch-complete pulse.
REQ-018 SHALL have port timeout_err  output  1  sticky flag: a challenge got no response.

Function
REQ-019 SHALL implement the states IDLE, ISSUE, WAIT, DELIVER and FINISH.
REQ-020 In IDLE, start=1 SHALL latch seed and count and go to ISSUE, or to FINISH if count=0; busy SHALL be 1 in every state except IDLE.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 ISSUE SHALL assert map_trigger for exactly one cycle, clear the wait counter and go to WAIT.
REQ-023 map_challenge SHALL be stable from ISSUE until WAIT is exited.
REQ-024 WAIT SHALL increment the wait counter each cycle.
REQ-025 In WAIT, map_done=1 SHALL capture map_data into resp_data, set resp_valid and go to DELIVER.
REQ-026 In WAIT, if map_done is not seen and the counter reaches TIMEOUT, the block SHALL set timeout_err and go to FINISH, aborting the rest of the batch.
REQ-027 If map_done and the timeout occur in the same cycle, map_done SHALL take priority.
REQ-028 In DELIVER, resp_valid SHALL hold with resp_data stable until resp_ready=1; this gives the one-cycle gap the responder needs to return to idle.
REQ-029 On the resp_ready=1 cycle in DELIVER, the block SHALL clear resp_valid and decrement the remaining count.
REQ-030 On that same cycle, the block SHALL advance to the next challenge and go to ISSUE, or go to FINISH if the remaining count is 0.
REQ-031 A map_done arriving outside WAIT SHALL be ignored.
REQ-032 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-033 timeout_err SHALL stay set until the next accepted start clears it.
REQ-034 Without the LFSR option, the next challenge SHALL be the current challenge + 1 modulo 2^IN_WIDTH, wrapping from all-ones to zero.
REQ-035 Trigger-to-response latency SHALL be responder latency + 1 cycle.

Reset
REQ-036 While reset=1, the state SHALL be IDLE and all outputs 0: map_trigger, map_challenge, resp_valid, resp_data, busy, done, timeout_err.
REQ-037 Internal counters SHALL also be 0 during reset.
REQ-038 Reset mid-batch SHALL abandon the batch immediately with no done pulse.

Configuration
REQ-039 With PUF_QUERY_LFSR_EN defined, the next challenge SHALL be a Fibonacci LFSR step of the current challenge.
REQ-040 The LFSR step SHALL be {c[126:0], c[127]^c[125]^c[100]^c[98]} (IN_WIDTH=128 only).
REQ-041 With PUF_QUERY_LFSR_EN defined, a zero seed SHALL be replaced by 1.
REQ-042 Without PUF_QUERY_LFSR_EN, challenges SHALL increment per REQ-034.

Verification
REQ-043 Bench SHALL cover: seed=0x...0005, count=3, responder latency 16, resp_ready tied 1 -> three triggers with challenges 5, 6, 7, three resp_valid pulses carrying the responder data, then one done pulse, timeout_err=0.
REQ-044 Bench SHALL cover: count=0 with start -> no map_trigger, and done pulses within 2 cycles.
REQ-045 Bench SHALL cover: responder never asserts map_done with TIMEOUT=32 -> timeout_err=1 exactly 32 cycles after the trigger, then done, and no further triggers.
REQ-046 Bench SHALL cover: resp_ready held 0 for 10 cycles -> resp_valid and resp_data stable, and no new trigger until acceptance.
REQ-047 Bench SHALL cover: seed=all-ones, count=2 (LFSR disabled) -> second challenge is 0.
REQ-048 Bench SHALL cover: reset asserted during WAIT -> all outputs 0 asynchronously, no done pulse, and a later start runs normally.
